// File: rtl/pbvi_step1.sv
// pbvi_step1: projection stage of the PBVI backup for a 2-state, 3-action,
// 2-observation POMDP with 16 alpha vectors. After a start pulse it computes
// gamma[a][o][i][s] = discount * sum_s' trans[a][s][s'] * observe[a][s'][o] * alpha[i][s'],
// one action per cycle, then pulses en_step1 for one cycle.
module pbvi_step1 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] discount,
    input  logic [15:0] alpha   [0:15][0:1],
    input  logic [15:0] trans   [0:2][0:1][0:1],
    input  logic [15:0] observe [0:2][0:1][0:1],
    output logic        en_step1,
    output logic [15:0] gamma_intermediate_action_observation_alpha [0:2][0:1][0:15][0:1]
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  act_q, act_d;
    logic        latch;

    logic [15:0] discount_q;
    logic [15:0] alpha_q   [0:15][0:1];
    logic [15:0] trans_q   [0:2][0:1][0:1];
    logic [15:0] observe_q [0:2][0:1][0:1];

    logic [15:0] gamma_q   [0:2][0:1][0:15][0:1];
    logic [15:0] gamma_act [0:1][0:15][0:1];

    // One gamma entry: truncating Q0.16 products, 17-bit sum saturated to 16 bits.
    function automatic logic [15:0] gamma_entry(
        input logic [15:0] tr0, input logic [15:0] tr1,
        input logic [15:0] ob0, input logic [15:0] ob1,
        input logic [15:0] al0, input logic [15:0] al1,
        input logic [15:0] disc
    );
        logic [15:0] p0, p1, t0, t1, sat;
        logic [16:0] sum;
        p0  = 16'((32'(tr0) * 32'(ob0)) >> 16);
        p1  = 16'((32'(tr1) * 32'(ob1)) >> 16);
        t0  = 16'((32'(p0) * 32'(al0)) >> 16);
        t1  = 16'((32'(p1) * 32'(al1)) >> 16);
        sum = 17'(t0) + 17'(t1);
        sat = sum[16] ? 16'hFFFF : sum[15:0];
        return 16'((32'(sat) * 32'(disc)) >> 16);
    endfunction

    // Next-state logic; the done cycle also samples en so restarts can land every 4 cycles.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        latch   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (en) begin
                    latch   = 1'b1;
                    act_d   = 2'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (act_q == 2'd2) begin
                    state_d = StDone;
                end else begin
                    act_d = act_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and action-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            act_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
        end
    end

    // Snapshot of all operands taken when a run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            discount_q <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                for (int s = 0; s < 2; s++) begin
                    alpha_q[i][s] <= 16'd0;
                end
            end
            for (int a = 0; a < 3; a++) begin
                for (int j = 0; j < 2; j++) begin
                    for (int k = 0; k < 2; k++) begin
                        trans_q[a][j][k]   <= 16'd0;
                        observe_q[a][j][k] <= 16'd0;
                    end
                end
            end
        end else if (latch) begin
            discount_q <= discount;
            alpha_q    <= alpha;
            trans_q    <= trans;
            observe_q  <= observe;
        end
    end

    // All 64 entries of the current action, from the latched operands.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 16; i++) begin
                for (int s = 0; s < 2; s++) begin
                    gamma_act[o][i][s] = gamma_entry(
                        trans_q[act_q][s][0], trans_q[act_q][s][1],
                        observe_q[act_q][0][o], observe_q[act_q][1][o],
                        alpha_q[i][0], alpha_q[i][1],
                        discount_q);
                end
            end
        end
    end

    // Output array: cleared on reset, one action slice written per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 3; a++) begin
                for (int o = 0; o < 2; o++) begin
                    for (int i = 0; i < 16; i++) begin
                        for (int s = 0; s < 2; s++) begin
                            gamma_q[a][o][i][s] <= 16'd0;
                        end
                    end
                end
            end
        end else if (state_q == StCalc) begin
            for (int o = 0; o < 2; o++) begin
                for (int i = 0; i < 16; i++) begin
                    for (int s = 0; s < 2; s++) begin
                        gamma_q[act_q][o][i][s] <= gamma_act[o][i][s];
                    end
                end
            end
        end
    end

    assign en_step1 = (state_q == StDone);
    assign gamma_intermediate_action_observation_alpha = gamma_q;

endmodule

// File: tb/tb_pbvi_step1.sv
// Self-checking bench for pbvi_step1: directed and random runs against an
// arithmetic reference model of the gamma projection.
module tb_pbvi_step1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] discount;
    logic [15:0] alpha   [0:15][0:1];
    logic [15:0] trans   [0:2][0:1][0:1];
    logic [15:0] observe [0:2][0:1][0:1];
    logic        en_step1;
    logic [15:0] g [0:2][0:1][0:15][0:1];

    int n_checks = 0;
    int n_fail   = 0;
    longint exp_g [0:2][0:1][0:15][0:1];

    always #5 clk = ~clk;

    pbvi_step1 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .discount (discount),
        .alpha    (alpha),
        .trans    (trans),
        .observe  (observe),
        .en_step1 (en_step1),
        .gamma_intermediate_action_observation_alpha (g)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: floor arithmetic straight from the formula, on the current inputs.
    task automatic model_run();
        longint p, t, sum;
        for (int a = 0; a < 3; a++)
            for (int o = 0; o < 2; o++)
                for (int i = 0; i < 16; i++)
                    for (int s = 0; s < 2; s++) begin
                        sum = 0;
                        for (int sp = 0; sp < 2; sp++) begin
                            p   = (longint'(trans[a][s][sp]) * longint'(observe[a][sp][o])) / 65536;
                            t   = (p * longint'(alpha[i][sp])) / 65536;
                            sum = sum + t;
                        end
                        if (sum > 65535) sum = 65535;
                        exp_g[a][o][i][s] = (sum * longint'(discount)) / 65536;
                    end
    endtask

    task automatic chk_action(input int a, input string tag);
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 16; i++)
                for (int s = 0; s < 2; s++)
                    chk($sformatf("%s g[%0d][%0d][%0d][%0d]", tag, a, o, i, s),
                        64'(g[a][o][i][s]), 64'(exp_g[a][o][i][s]));
    endtask

    task automatic chk_const(input string tag, input logic [15:0] v);
        for (int a = 0; a < 3; a++)
            for (int o = 0; o < 2; o++)
                for (int i = 0; i < 16; i++)
                    for (int s = 0; s < 2; s++)
                        chk($sformatf("%s g[%0d][%0d][%0d][%0d]", tag, a, o, i, s),
                            64'(g[a][o][i][s]), 64'(v));
    endtask

    task automatic clear_inputs();
        discount = 16'd0;
        for (int i = 0; i < 16; i++)
            for (int s = 0; s < 2; s++) alpha[i][s] = 16'd0;
        for (int a = 0; a < 3; a++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    trans[a][j][k]   = 16'd0;
                    observe[a][j][k] = 16'd0;
                end
    endtask

    task automatic randomize_alpha();
        for (int i = 0; i < 16; i++)
            for (int s = 0; s < 2; s++) alpha[i][s] = 16'($urandom);
    endtask

    task automatic randomize_inputs();
        discount = 16'($urandom);
        randomize_alpha();
        for (int a = 0; a < 3; a++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    trans[a][j][k]   = 16'($urandom);
                    observe[a][j][k] = 16'($urandom);
                end
    endtask

    // Bounded wait for the done pulse; an expired budget shows up as a failed check.
    task automatic wait_done(input string tag);
        for (int c = 0; c < 12; c++) begin
            if (en_step1) break;
            step();
        end
        chk(tag, 64'(en_step1), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clear_inputs();
        step();
        step();
        step();
        rst = 1'b0;
        chk("reset en_step1", 64'(en_step1), 64'd0);
        chk_const("reset", 16'd0);

        // Directed run with known values and cycle-by-cycle timing.
        randomize_alpha();
        alpha[0][0] = 16'd13464; alpha[0][1] = 16'd20673;
        alpha[7][0] = 16'd20035; alpha[7][1] = 16'd20035;
        discount = 16'hC000;
        for (int a = 0; a < 2; a++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    trans[a][j][k]   = 16'h8000;
                    observe[a][j][k] = 16'h8000;
                end
        trans[2][0][0] = 16'hFFFF; trans[2][0][1] = 16'h0000;
        trans[2][1][0] = 16'h0000; trans[2][1][1] = 16'hFFFF;
        observe[2][0][0] = 16'd55706; observe[2][0][1] = 16'd9830;
        observe[2][1][0] = 16'd9830;  observe[2][1][1] = 16'd55706;
        model_run();
        en = 1'b1;
        step();                                   // edge N
        en = 1'b0;
        randomize_alpha();                        // must not disturb the run in flight
        chk("N done", 64'(en_step1), 64'd0);
        chk("N a0 not yet", 64'(g[0][0][0][0]), 64'd0);
        step();                                   // edge N+1
        chk_action(0, "N+1");
        chk("N+1 a1 old", 64'(g[1][0][0][0]), 64'd0);
        chk("N+1 a2 old", 64'(g[2][0][0][0]), 64'd0);
        chk("N+1 done", 64'(en_step1), 64'd0);
        step();                                   // edge N+2
        chk_action(1, "N+2");
        chk("N+2 a2 old", 64'(g[2][0][0][0]), 64'd0);
        chk("N+2 done", 64'(en_step1), 64'd0);
        step();                                   // edge N+3
        chk("N+3 done", 64'(en_step1), 64'd1);
        chk_action(0, "N+3");
        chk_action(1, "N+3");
        chk_action(2, "N+3");
        for (int a = 0; a < 2; a++)
            for (int o = 0; o < 2; o++)
                for (int s = 0; s < 2; s++) begin
                    chk($sformatf("known g[%0d][%0d][0][%0d]", a, o, s), 64'(g[a][o][0][s]), 64'd6400);
                    chk($sformatf("known g[%0d][%0d][7][%0d]", a, o, s), 64'(g[a][o][7][s]), 64'd7512);
                end
        chk("known g[2][0][0][0]", 64'(g[2][0][0][0]), 64'd8583);
        chk("known g[2][1][0][0]", 64'(g[2][1][0][0]), 64'd1514);
        chk("known g[2][0][0][1]", 64'(g[2][0][0][1]), 64'd2325);
        step();                                   // edge N+4
        chk("N+4 done", 64'(en_step1), 64'd0);
        chk("N+4 hold", 64'(g[0][0][0][0]), 64'd6400);

        // Saturation corner.
        discount = 16'hFFFF;
        for (int i = 0; i < 16; i++)
            for (int s = 0; s < 2; s++) alpha[i][s] = 16'hFFFF;
        for (int a = 0; a < 3; a++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    trans[a][j][k]   = 16'hFFFF;
                    observe[a][j][k] = 16'hFFFF;
                end
        en = 1'b1;
        step();
        en = 1'b0;
        wait_done("sat done");
        chk_const("sat", 16'hFFFE);
        step();

        // Back-to-back runs with en held high; inputs change mid-run.
        randomize_inputs();
        model_run();
        en = 1'b1;
        step();                                   // edge N
        randomize_inputs();
        step();
        step();
        step();                                   // edge N+3
        chk("b2b first done", 64'(en_step1), 64'd1);
        for (int a = 0; a < 3; a++) chk_action(a, "b2b run1");
        randomize_inputs();
        model_run();
        step();                                   // edge N+4: restart accepted
        chk("b2b N+4 done", 64'(en_step1), 64'd0);
        step();
        step();
        step();                                   // edge N+7
        chk("b2b second done", 64'(en_step1), 64'd1);
        for (int a = 0; a < 3; a++) chk_action(a, "b2b run2");
        en = 1'b0;
        step();
        chk("b2b idle", 64'(en_step1), 64'd0);

        // Reset two cycles into a run.
        randomize_inputs();
        en = 1'b1;
        step();                                   // edge N
        en = 1'b0;
        step();                                   // edge N+1
        rst = 1'b1;
        step();                                   // edge N+2
        rst = 1'b0;
        chk("abort done", 64'(en_step1), 64'd0);
        chk_const("abort", 16'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("abort quiet %0d", c), 64'(en_step1), 64'd0);
        end
        randomize_inputs();
        model_run();
        en = 1'b1;
        step();
        en = 1'b0;
        wait_done("post-abort done");
        for (int a = 0; a < 3; a++) chk_action(a, "post-abort");
        step();

        // A few more random runs.
        for (int r = 0; r < 3; r++) begin
            randomize_inputs();
            model_run();
            en = 1'b1;
            step();
            en = 1'b0;
            wait_done($sformatf("rand%0d done", r));
            for (int a = 0; a < 3; a++) chk_action(a, $sformatf("rand%0d", r));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
